// File: rtl/rr_pop_arbiter.sv
// rr_pop_arbiter: round-robin pop arbiter in front of four first-word-fall-through FIFOs.
// A queue that wins the grant may be popped up to QUANTUM times in a row. The grant then
// moves to the next non-empty queue in the same cycle, so the hand-over costs no bubble.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   empty[3:0]   per-queue empty flags
//   fifo_data    queue heads; queue i at [i*DATA_W +: DATA_W]
//   almost_full  downstream backpressure; no pop is issued while it is high
//   pop[3:0]     one-hot pop strobe, combinational
//   data_out     registered popped entry
//   pop_id       registered index of the queue that produced data_out
//   valid        registered one-cycle strobe, one per popped entry
//   pop_count    (only with RR_POP_STATS_EN) four saturating 16-bit pop counters,
//                counter i at [i*16 +: 16]
//
// Optional feature macro: RR_POP_STATS_EN
//
// state  | meaning
// IDLE   | no grant held; search starts at ptr
// BURST  | grant held on gnt, cnt pops issued so far in this burst
module rr_pop_arbiter #(
   parameter int DATA_W  = 10,
   parameter int QUANTUM = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          empty,
   input  logic [4*DATA_W-1:0] fifo_data,
   input  logic                almost_full,
   output logic [3:0]          pop,
   output logic [DATA_W-1:0]   data_out,
   output logic [1:0]          pop_id,
   output logic                valid
`ifdef RR_POP_STATS_EN
   ,
   output logic [63:0]         pop_count
`endif
);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   localparam logic [3:0] QUANT = 4'(QUANTUM);

   state_t              state_q, state_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_out_q;
   logic [1:0]          pop_id_q;
   logic                valid_q;

   logic                burst_done;
   logic [1:0]          base;
   logic [1:0]          idx;
   logic [1:0]          sel;
   logic                found;
   logic                pop_en;
   logic [1:0]          pop_idx;
   logic [DATA_W-1:0]   head [4];

   // A finished (or drained) burst searches from the queue after the grant holder.
   // The same base feeds the pointer update, so a drain coinciding with quantum
   // expiry advances the pointer only once.
   assign burst_done = (state_q == ST_BURST) && ((cnt_q >= QUANT) || empty[gnt_q]);
   assign base       = burst_done ? gnt_q + 2'd1 : ptr_q;

   always_comb begin
      found = 1'b0;
      sel   = base;
      idx   = base;
      for (int k = 0; k < 4; k++) begin
         idx = base + 2'(k);
         if (!found && !empty[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      pop_en  = 1'b0;
      pop_idx = gnt_q;
      // Backpressure freezes everything, so a stall does not eat into the quantum.
      if (!almost_full) begin
         if ((state_q == ST_BURST) && !burst_done) begin
            pop_en  = 1'b1;
            pop_idx = gnt_q;
            cnt_d   = cnt_q + 4'd1;
         end else begin
            ptr_d = base;
            if (found) begin
               pop_en  = 1'b1;
               pop_idx = sel;
               gnt_d   = sel;
               cnt_d   = 4'd1;
               state_d = ST_BURST;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   // Gated by reset so no strobe reaches the FIFOs while reset is asserted.
   assign pop = (pop_en && reset) ? (4'b0001 << pop_idx) : 4'b0000;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         head[i] = fifo_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 2'd0;
         gnt_q      <= 2'd0;
         cnt_q      <= 4'd0;
         data_out_q <= '0;
         pop_id_q   <= 2'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         valid_q <= pop_en;
         if (pop_en) begin
            data_out_q <= head[pop_idx];
            pop_id_q   <= pop_idx;
         end
      end
   end

   assign data_out = data_out_q;
   assign pop_id   = pop_id_q;
   assign valid    = valid_q;

`ifdef RR_POP_STATS_EN
   logic [15:0] stat_q [4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) stat_q[i] <= 16'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (pop[i] && (stat_q[i] != 16'hFFFF)) stat_q[i] <= stat_q[i] + 16'd1;
         end
      end
   end

   assign pop_count = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif

endmodule

// File: doc/rr_pop_arbiter.md
RR_POP_ARBITER -- requirements
Module: rr_pop_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 10, which is the width of one queue entry.
REQ-002 SHALL have parameter QUANTUM, default 2, which is the maximum consecutive pops per grant (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port empty, input, 4 bits: per-queue empty flags from four first-word-fall-through FIFOs.
REQ-006 SHALL have port fifo_data, input, 4*DATA_W bits: queue i head at [i*DATA_W +: DATA_W].
REQ-007 SHALL have port almost_full, input, 1 bit: downstream backpressure; no pop issued while high.
REQ-008 SHALL have port pop, output, 4 bits: one-hot pop strobe to the FIFOs, combinational from current state and inputs.
REQ-009 SHALL have port data_out, output, DATA_W bits: registered popped entry.
REQ-010 SHALL have port pop_id, output, 2 bits: registered index of the queue that produced data_out.
REQ-011 SHALL have port valid, output, 1 bit: registered, high for exactly one cycle per popped entry.

Function
REQ-012 SHALL implement FSM states IDLE (no grant held) and BURST (grant held on queue gnt, burst counter cnt).
REQ-013 In IDLE, with almost_full=0 and empty!=4'b1111, SHALL select the first non-empty queue searching ptr, ptr+1, ... mod 4, pop it that cycle, set gnt=sel, set cnt=1, and go to BURST.
REQ-014 In BURST, with almost_full=0, empty[gnt]=0 and cnt<QUANTUM, SHALL pop gnt again and increment cnt.
REQ-015 In BURST, when cnt==QUANTUM or empty[gnt]=1, SHALL set ptr=(gnt+1) mod 4 and behave as IDLE in the same cycle, so that a pop to the next eligible queue is issued without a bubble.
REQ-016 With almost_full=1, SHALL drive pop=0 and hold gnt, cnt, and ptr; the stall does not consume quantum.
REQ-017 SHALL never assert more than one pop bit, and SHALL never pop a queue whose empty bit is 1.
REQ-018 Latency: on the cycle after pop[i]=1, SHALL present valid=1, pop_id=i, and data_out equal to the fifo_data head of queue i sampled at the pop edge.
REQ-019 If no pop occurs, SHALL drive valid=0 next cycle and hold data_out and pop_id at their last values.
REQ-020 ptr and pop_id SHALL wrap 3->0 modulo 4.
REQ-021 If all queues empty, SHALL return to IDLE with ptr=(gnt+1) mod 4.
REQ-022 If empty[gnt] rises in the same cycle as cnt reaches QUANTUM, SHALL apply a single pointer advance (no double skip).

Reset
REQ-023 On reset=0, SHALL asynchronously force state=IDLE, ptr=0, gnt=0, cnt=0, valid=0, pop_id=0, data_out=0, and pop=0.
REQ-024 An in-flight pop cut by reset mid-burst SHALL produce no valid; after release, arbitration SHALL restart from queue 0.
REQ-025 SHALL leave reset on the first rising clk edge after reset=1.

Configuration
REQ-026 With macro RR_POP_STATS_EN defined, SHALL add output pop_count, 64 bits: four 16-bit counters, counter i at [i*16 +: 16], each incrementing on every pop[i], saturating at 16'hFFFF, and reset to 0.
REQ-027 Without RR_POP_STATS_EN, port pop_count and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 All queues non-empty, QUANTUM=2, almost_full=0 -> pop_id sequence 0,0,1,1,2,2,3,3,0 on consecutive cycles, with valid constantly 1.
REQ-029 empty=4'b1010, QUANTUM=1 -> pops alternate between queues 0 and 2; queues 1 and 3 are never popped.
REQ-030 Queue 1 holds 1 entry, others empty, QUANTUM=2 -> a single pop on queue 1, then valid=0; the next grant search starts at queue 2.
REQ-031 almost_full=1 for 3 cycles mid-burst (cnt=1) -> pop=0 and valid=0 during the stall; the burst resumes on the same queue for 1 more pop.
REQ-032 Assert reset=0 during BURST on queue 2 -> outputs clear immediately; after release with all queues full, the first pop_id is 0.
REQ-033 With RR_POP_STATS_EN, 70000 pops on queue 3 -> pop_count[63:48]=16'hFFFF and the other counters are 0.
